dbc_port_status_gen: RTL
========================

// Module: dbc_port_status_gen
// PURPOSE
//  Producer side of the DbC port status/change interface consumed by DbCPortStatMachine.
//  Tracks the DbC port state from link-layer events and software enable.
//  Generates registered status and change bits: CCS, PED, PLS, CSC, PRC, PLC, CEC.
//  Also generates the enable echo DCE and the interrupt DCI.
//  Change bits are sticky and cleared by software write-1-to-clear (RW1C).
// PARAMETERS
//  DEBOUNCE_CYCLES  16  cycles link_connect must hold a new level before it is accepted (>=1)
//  CNT_W            5   debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clock          in   1  single clock; all logic on posedge
//  reset          in   1  synchronous, active-low reset
//  sw_dce         in   1  software DbC enable (level)
//  sw_int_en      in   1  software interrupt enable (level)
//  sw_w1c_valid   in   1  RW1C write strobe, 1 cycle
//  sw_w1c_mask    in   4  {CEC,PLC,PRC,CSC}; a 1 clears that bit
//  link_connect   in   1  raw connect level from PHY/link (may bounce)
//  link_state     in   4  current port link state code from link layer
//  port_rst_act   in   1  host-driven port reset in progress (level)
//  port_rst_done  in   1  reset completed, 1-cycle pulse
//  cfg_error      in   1  configuration error, 1-cycle pulse
//  DCE            out  1  DbC enabled (registered copy of sw_dce)
//  CCS            out  1  current connect status (debounced)
//  PED            out  1  port enabled
//  PLS            out  4  registered link_state
//  CSC            out  1  connect status change (sticky)
//  PRC            out  1  port reset change (sticky)
//  PLC            out  1  port link state change (sticky)
//  CEC            out  1  config error change (sticky)
//  DCI            out  1  interrupt = sw_int_en & (CSC|PRC|PLC|CEC), registered
//  port_state     out  3  FSM state for debug
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - All outputs 0; port_state=OFF; debounce counter 0; accepted connect level 0.
//  FSM states: OFF=0, DISCONN=1, CONNECTED=2, RESETTING=3, ENABLED=4, ERROR=5.
//  Global: sw_dce==0 in any state -> OFF next cycle.
//   - On entering OFF: CCS, PED, PLS, all change bits, DCI and debounce state cleared.
//  OFF -> DISCONN when sw_dce==1; DCE=1 the same cycle the transition registers.
//  Debounce:
//   - Counter counts while link_connect != accepted level.
//   - Counter resets to 0 on any cycle where the levels match.
//   - Accepted level flips when counter reaches DEBOUNCE_CYCLES-1.
//   - Result: change is seen DEBOUNCE_CYCLES cycles after a stable edge.
//  DISCONN -> CONNECTED on accepted rise: CCS<=1, CSC<=1.
//  CONNECTED -> RESETTING when port_rst_act==1.
//  RESETTING -> ENABLED on port_rst_done: PED<=1, PRC<=1.
//  ENABLED:
//   - cfg_error -> ERROR: PED<=0, CEC<=1.
//   - port_rst_act -> RESETTING: PED<=0.
//  ERROR -> RESETTING when port_rst_act==1.
//  CONNECTED/RESETTING/ENABLED/ERROR -> DISCONN on accepted fall: CCS<=0, PED<=0, CSC<=1.
//  Same-cycle event priority:
//   - sw_dce==0 > accepted disconnect > port_rst_act > port_rst_done > cfg_error.
//   - Lower-priority events that cycle are dropped; their change bits are not set.
//  PLS is updated every cycle while state != OFF.
//   - PLC<=1 when link_state != PLS, outside OFF.
//  RW1C: a change bit that is set by an event in the same cycle it is cleared stays 1 (set wins).
//  Change bits never self-clear except by RW1C, entry to OFF, or reset.
//  DCI is registered from the next-state change bits:
//   - rises 1 cycle after a change bit sets; falls 1 cycle after the last one clears;
//   - follows sw_int_en with 1-cycle latency.
//  Pulses port_rst_done and cfg_error arriving in a state that does not use them are ignored.
// TESTING
//  Reset: hold reset=0 3 cycles, then release with sw_dce=0 -> all outputs 0, port_state=0.
//  sw_dce=1 -> DCE=1, state=DISCONN.
//   - Bounce link_connect 1,0,1 with gaps < DEBOUNCE_CYCLES -> CCS stays 0.
//   - Then hold link_connect=1 for 16 cycles -> CCS=1, CSC=1, state=CONNECTED.
//  port_rst_act=1 then port_rst_done pulse -> state=ENABLED, PED=1, PRC=1.
//   - With sw_int_en=1: DCI=1 one cycle after PRC; w1c mask 4'b0011 -> CSC=PRC=0, DCI=0 next cycle.
//  In ENABLED: cfg_error pulse + w1c mask 4'b1000 in the same cycle -> CEC=1 (set wins), PED=0, state=ERROR.
//  link_state 4'h0 -> 4'h3 -> PLS=3, PLC=1.
//   - Drop link_connect for 16 cycles -> CCS=0, PED=0, CSC=1, state=DISCONN.
//  Clear sw_dce mid-RESETTING -> next cycle state=OFF, DCE=0, all change bits and DCI 0.

Source files
------------

// File: rtl/dbc_port_status_gen_if.sv
// Status/change signal bundle between the DbC port producer and its environment.
// The producer (slave) takes the software and link inputs and drives the registered status.
interface dbc_port_status_gen_if;
   logic       sw_dce;
   logic       sw_int_en;
   logic       sw_w1c_valid;
   logic [3:0] sw_w1c_mask;
   logic       link_connect;
   logic [3:0] link_state;
   logic       port_rst_act;
   logic       port_rst_done;
   logic       cfg_error;
   logic       DCE;
   logic       CCS;
   logic       PED;
   logic [3:0] PLS;
   logic       CSC;
   logic       PRC;
   logic       PLC;
   logic       CEC;
   logic       DCI;
   logic [2:0] port_state;

   modport master (
      output sw_dce, sw_int_en, sw_w1c_valid, sw_w1c_mask, link_connect,
             link_state, port_rst_act, port_rst_done, cfg_error,
      input  DCE, CCS, PED, PLS, CSC, PRC, PLC, CEC, DCI, port_state
   );

   modport slave (
      input  sw_dce, sw_int_en, sw_w1c_valid, sw_w1c_mask, link_connect,
             link_state, port_rst_act, port_rst_done, cfg_error,
      output DCE, CCS, PED, PLS, CSC, PRC, PLC, CEC, DCI, port_state
   );
endinterface

// File: rtl/dbc_port_status_gen.sv
// DbC port state tracker producing registered status, sticky RW1C change bits and interrupt.
// All outputs update one cycle after their cause; no backpressure, inputs are sampled every cycle.
module dbc_port_status_gen #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5
) (
   input logic                  clock,
   input logic                  reset,
   dbc_port_status_gen_if.slave ps
);

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_DISCONN   = 3'd1,
      ST_CONNECTED = 3'd2,
      ST_RESETTING = 3'd3,
      ST_ENABLED   = 3'd4,
      ST_ERROR     = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] deb_cnt, deb_cnt_nxt;
   logic             acc_lvl, acc_lvl_nxt;
   logic             dce;
   logic             ccs, ccs_nxt;
   logic             ped, ped_nxt;
   logic [3:0]       pls, pls_nxt;
   logic             csc, csc_nxt;
   logic             prc, prc_nxt;
   logic             plc, plc_nxt;
   logic             cec, cec_nxt;
   logic             dci, dci_nxt;
   logic             active;
   logic             acc_rise, acc_fall;
   logic             set_csc, set_prc, set_plc, set_cec;
   logic [3:0]       clr;

   always_comb begin
      state_nxt   = state;
      deb_cnt_nxt = deb_cnt;
      acc_lvl_nxt = acc_lvl;
      ccs_nxt     = ccs;
      ped_nxt     = ped;
      pls_nxt     = pls;
      acc_rise    = 1'b0;
      acc_fall    = 1'b0;
      set_csc     = 1'b0;
      set_prc     = 1'b0;
      set_plc     = 1'b0;
      set_cec     = 1'b0;
      active      = (state != ST_OFF) && ps.sw_dce;
      clr         = ps.sw_w1c_valid ? ps.sw_w1c_mask : 4'b0000;

      // Debounce and link-state tracking only run while the port is live.
      if (active) begin
         if (ps.link_connect != acc_lvl) begin
            if (deb_cnt == CNT_LAST) begin
               acc_lvl_nxt = ps.link_connect;
               deb_cnt_nxt = '0;
               acc_rise    = ps.link_connect;
               acc_fall    = !ps.link_connect;
            end else begin
               deb_cnt_nxt = deb_cnt + CNT_W'(1);
            end
         end else begin
            deb_cnt_nxt = '0;
         end
         pls_nxt = ps.link_state;
         set_plc = (ps.link_state != pls);
      end

      if (!ps.sw_dce) begin
         state_nxt = ST_OFF;
      end else begin
         unique case (state)
            ST_OFF: state_nxt = ST_DISCONN;
            ST_DISCONN: begin
               if (acc_rise) begin
                  state_nxt = ST_CONNECTED;
                  ccs_nxt   = 1'b1;
                  set_csc   = 1'b1;
               end
            end
            ST_CONNECTED, ST_RESETTING, ST_ENABLED, ST_ERROR: begin
               // A debounced disconnect pre-empts every port event in the same cycle.
               if (acc_fall) begin
                  state_nxt = ST_DISCONN;
                  ccs_nxt   = 1'b0;
                  ped_nxt   = 1'b0;
                  set_csc   = 1'b1;
               end else if (state == ST_RESETTING) begin
                  if (ps.port_rst_done) begin
                     state_nxt = ST_ENABLED;
                     ped_nxt   = 1'b1;
                     set_prc   = 1'b1;
                  end
               end else if (ps.port_rst_act) begin
                  state_nxt = ST_RESETTING;
                  ped_nxt   = 1'b0;
               end else if (state == ST_ENABLED && ps.cfg_error) begin
                  state_nxt = ST_ERROR;
                  ped_nxt   = 1'b0;
                  set_cec   = 1'b1;
               end
            end
            default: state_nxt = ST_OFF;
         endcase
      end

      // Set wins over a simultaneous write-1-to-clear.
      csc_nxt = (csc & ~clr[0]) | set_csc;
      prc_nxt = (prc & ~clr[1]) | set_prc;
      plc_nxt = (plc & ~clr[2]) | set_plc;
      cec_nxt = (cec & ~clr[3]) | set_cec;

      if (state_nxt == ST_OFF) begin
         deb_cnt_nxt = '0;
         acc_lvl_nxt = 1'b0;
         ccs_nxt     = 1'b0;
         ped_nxt     = 1'b0;
         pls_nxt     = 4'h0;
         csc_nxt     = 1'b0;
         prc_nxt     = 1'b0;
         plc_nxt     = 1'b0;
         cec_nxt     = 1'b0;
      end

      dci_nxt = ps.sw_int_en & (csc_nxt | prc_nxt | plc_nxt | cec_nxt);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= ST_OFF;
         deb_cnt <= '0;
         acc_lvl <= 1'b0;
         dce     <= 1'b0;
         ccs     <= 1'b0;
         ped     <= 1'b0;
         pls     <= 4'h0;
         csc     <= 1'b0;
         prc     <= 1'b0;
         plc     <= 1'b0;
         cec     <= 1'b0;
         dci     <= 1'b0;
      end else begin
         state   <= state_nxt;
         deb_cnt <= deb_cnt_nxt;
         acc_lvl <= acc_lvl_nxt;
         dce     <= ps.sw_dce;
         ccs     <= ccs_nxt;
         ped     <= ped_nxt;
         pls     <= pls_nxt;
         csc     <= csc_nxt;
         prc     <= prc_nxt;
         plc     <= plc_nxt;
         cec     <= cec_nxt;
         dci     <= dci_nxt;
      end
   end

   assign ps.DCE        = dce;
   assign ps.CCS        = ccs;
   assign ps.PED        = ped;
   assign ps.PLS        = pls;
   assign ps.CSC        = csc;
   assign ps.PRC        = prc;
   assign ps.PLC        = plc;
   assign ps.CEC        = cec;
   assign ps.DCI        = dci;
   assign ps.port_state = state;

endmodule
